puf_sig_verifier: RTL and testbench

- Read side of the RO-PUF signature path.
- Fetches the enrolled signature that the PUF controller wrote into signature RAM, one word at a time.
- Compares it bit-by-bit against a freshly regenerated response stream (one comparator bit per challenge) and accumulates the Hamming distance.
- Issues pass/fail against a fixed threshold. Sits between the PUF controller/comparator output and the RAM read port.

---
 rtl/puf_pkg.sv | 20 ++
 rtl/puf_hd_accum.sv | 65 ++++++
 rtl/puf_sig_verifier.sv | 134 +++++++++++++
 tb/tb_puf_sig_verifier.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared RO-PUF definitions used by the signature verifier, the PUF controller
// and the enrollment RAM wrapper: default geometry, verdict threshold and the
// verifier state encoding.
package puf_pkg;

  localparam int RO_NO     = 256;  // challenges / signature bits per authentication
  localparam int WORD_W    = 8;    // signature RAM word width
  localparam int ADDR_W    = 5;    // clog2(RO_NO/WORD_W)
  localparam int HD_W      = 9;    // clog2(RO_NO+1)
  localparam int HD_THRESH = 25;   // largest Hamming distance that still passes

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/puf_hd_accum.sv
// Hamming-distance datapath: WORD_W-bit shift buffer, XOR against the response
// bit, hd counter and global bit index. Single-cycle update per control strobe.
// Ports: clk_i/rst_i; clear_i zeroes everything, load_i captures load_dat_i,
// shift_i consumes buf[0] against resp_bit_i; hd_o/hd_nxt_o/bit_idx_o report state.
module puf_hd_accum
  import puf_pkg::*;
#(
  parameter int RO_NO  = puf_pkg::RO_NO,
  parameter int WORD_W = puf_pkg::WORD_W,
  parameter int HD_W   = puf_pkg::HD_W,
  parameter int BIT_W  = $clog2(RO_NO)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_dat_i,
  input  logic              shift_i,
  input  logic              resp_bit_i,
  output logic [HD_W-1:0]   hd_o,
  output logic [HD_W-1:0]   hd_nxt_o,
  output logic [BIT_W-1:0]  bit_idx_o
);

  logic [WORD_W-1:0] buf_q, buf_d;
  logic [HD_W-1:0]   hd_q, hd_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic              mis;

  always_comb begin
    buf_d     = buf_q;
    hd_d      = hd_q;
    bit_idx_d = bit_idx_q;
    mis       = resp_bit_i ^ buf_q[0];
    if (clear_i) begin
      buf_d     = '0;
      hd_d      = '0;
      bit_idx_d = '0;
    end else if (load_i) begin
      buf_d = load_dat_i;
    end else if (shift_i) begin
      // LSB is the next signature bit; hd cannot exceed RO_NO so no saturation.
      buf_d     = {1'b0, buf_q[WORD_W-1:1]};
      hd_d      = hd_q + HD_W'(mis);
      bit_idx_d = bit_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q     <= '0;
      hd_q      <= '0;
      bit_idx_q <= '0;
    end else begin
      buf_q     <= buf_d;
      hd_q      <= hd_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign hd_o      = hd_q;
  assign hd_nxt_o  = hd_d;
  assign bit_idx_o = bit_idx_q;

endmodule

// File: rtl/puf_sig_verifier.sv
// Reads the enrolled PUF signature word by word and compares it LSB-first with
// the regenerated response stream; verdict pass = hd <= HD_THRESH. Latency with
// continuous resp_valid: RO_NO + 2*(RO_NO/WORD_W) + 1 cycles from start-accept to done.
// Backpressure: resp_ready only in COMPARE; resp_valid low stalls indefinitely.
// Ports: clk/rst; start; resp_bit/resp_valid/resp_ready stream; ram_rden/ram_rdaddr/
// ram_rddata (1-cycle read latency); busy/done/pass/hd status and verdict.
module puf_sig_verifier
  import puf_pkg::*;
#(
  parameter int RO_NO     = puf_pkg::RO_NO,
  parameter int WORD_W    = puf_pkg::WORD_W,
  parameter int ADDR_W    = puf_pkg::ADDR_W,
  parameter int HD_W      = puf_pkg::HD_W,
  parameter int HD_THRESH = puf_pkg::HD_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              resp_bit,
  input  logic              resp_valid,
  output logic              resp_ready,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [WORD_W-1:0] ram_rddata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [HD_W-1:0]   hd
);

  localparam int BIT_W = $clog2(RO_NO);
  localparam int WB    = $clog2(WORD_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic              pass_q, pass_d;

  logic              acc_clear, acc_load, acc_shift;
  logic [HD_W-1:0]   hd_cur, hd_nxt;
  logic [BIT_W-1:0]  bit_idx;
  logic              last_in_word, last_bit;

  puf_hd_accum #(
    .RO_NO  (RO_NO),
    .WORD_W (WORD_W),
    .HD_W   (HD_W),
    .BIT_W  (BIT_W)
  ) u_accum (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (acc_clear),
    .load_i     (acc_load),
    .load_dat_i (ram_rddata),
    .shift_i    (acc_shift),
    .resp_bit_i (resp_bit),
    .hd_o       (hd_cur),
    .hd_nxt_o   (hd_nxt),
    .bit_idx_o  (bit_idx)
  );

  assign last_in_word = (bit_idx[WB-1:0] == WB'(WORD_W - 1));
  assign last_bit     = (bit_idx == BIT_W'(RO_NO - 1));

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    pass_d      = pass_q;
    acc_clear   = 1'b0;
    acc_load    = 1'b0;
    acc_shift   = 1'b0;
    resp_ready  = 1'b0;
    ram_rden    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          word_addr_d = '0;
          pass_d      = 1'b0;
          acc_clear   = 1'b1;
        end
      end
      FETCH: begin
        busy     = 1'b1;
        ram_rden = 1'b1;
        state_d  = LOAD;
      end
      LOAD: begin
        // RAM data for the FETCH address is valid in this cycle.
        busy     = 1'b1;
        acc_load = 1'b1;
        state_d  = COMPARE;
      end
      COMPARE: begin
        busy       = 1'b1;
        resp_ready = 1'b1;
        if (resp_valid) begin
          acc_shift = 1'b1;
          if (last_bit) begin
            // Register the verdict with the final bit so it is valid alongside done.
            state_d = DONE;
            pass_d  = (hd_nxt <= HD_W'(HD_THRESH));
          end else if (last_in_word) begin
            word_addr_d = word_addr_q + 1'b1;
            state_d     = FETCH;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      pass_q      <= pass_d;
    end
  end

  assign ram_rdaddr = word_addr_q;
  assign pass       = pass_q;
  assign hd         = hd_cur;

endmodule

// File: tb/tb_puf_sig_verifier.sv
// Directed bench for puf_sig_verifier: behavioural signature RAM, response
// producer with optional random valid gaps, and a queue of expected hd values.
module tb_puf_sig_verifier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       resp_bit;
  logic       resp_valid;
  logic       resp_ready;
  logic       ram_rden;
  logic [4:0] ram_rdaddr;
  logic [7:0] ram_rddata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] hd;

  logic [7:0] mem [32];
  int         exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  puf_sig_verifier dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resp_bit   (resp_bit),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .ram_rden   (ram_rden),
    .ram_rdaddr (ram_rdaddr),
    .ram_rddata (ram_rddata),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .hd         (hd)
  );

  // Synchronous-read RAM: data valid the cycle after ram_rden.
  always @(posedge clk) begin
    if (ram_rden) ram_rddata <= mem[ram_rdaddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [255:0] v);
    int n = 0;
    for (int i = 0; i < 256; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic sig_bit(input int i);
    logic [7:0] w;
    w = mem[i / 8];
    return w[i % 8];
  endfunction

  // One verification. Called at #1 after a rising edge with the DUT in IDLE.
  task automatic run(input logic [255:0] flip, input bit rnd_valid, input int abort_at,
                     input bit repulse, input bit start_in_done, input bit chk_lat);
    int c = 0;
    int idx = 0;
    int nfetch = 0;
    int ndone = 0;
    int e_hd;
    bit prev_rden = 0;
    bit xfer = 0;
    bit pulsed = 0;
    if (abort_at == 0) exp_q.push_back(popc(flip));
    start = 1'b1;
    resp_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    check("busy_after_start", busy, 1);
    check("hd_cleared", hd, 0);
    while (c < 3000) begin
      if (ram_rden) begin
        check("rdaddr", ram_rdaddr, nfetch);
        check("ready_in_fetch", resp_ready, 0);
        nfetch++;
      end
      if (prev_rden) check("ready_in_load", resp_ready, 0);
      prev_rden = ram_rden;
      if (done) break;
      // Producer holds an unaccepted bit; otherwise offers a new one.
      if (!(resp_valid && !xfer))
        resp_valid = (idx < 256) ? (rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      resp_bit = (idx < 256) ? (sig_bit(idx) ^ flip[idx]) : 1'b0;
      if (repulse && idx == 40 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1;
      end
      xfer = resp_valid && resp_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer) idx++;
      c++;
      if (abort_at != 0 && idx == abort_at) begin
        rst = 1'b1;
        resp_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_hd", hd, 0);
        check("abort_done", done, 0);
        check("abort_ready", resp_ready, 0);
        for (int k = 0; k < 20; k++) begin
          if (done) ndone++;
          @(posedge clk); #1;
        end
        check("abort_no_done", ndone, 0);
        return;
      end
    end
    check("done_seen", done, 1);
    if (done) begin
      if (chk_lat) check("done_latency", c, 321);
      check("transfers", idx, 256);
      check("fetches", nfetch, 32);
      e_hd = exp_q.pop_front();
      check("hd", hd, e_hd);
      check("pass", pass, (e_hd <= 25) ? 1 : 0);
      start = start_in_done;
      @(posedge clk); #1;
      start = 1'b0;
      check("idle_busy", busy, 0);
      check("single_done", done, 0);
      check("hd_held", hd, e_hd);
      check("pass_held", pass, (e_hd <= 25) ? 1 : 0);
    end
  endtask

  initial begin
    logic [255:0] m;
    for (int i = 0; i < 32; i++) mem[i] = 8'hA5;
    rst = 1'b1;
    start = 1'b0;
    resp_bit = 1'b0;
    resp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_hd", hd, 0);
    check("rst_ready", resp_ready, 0);
    check("rst_rden", ram_rden, 0);
    check("rst_rdaddr", ram_rdaddr, 0);
    rst = 1'b0;

    // Identical stream, continuous valid.
    run('0, 0, 0, 0, 0, 1);
    // Fully inverted stream.
    m = '1;
    run(m, 0, 0, 0, 0, 1);
    // 25 mismatches: words 0, 15, 31 fully flipped plus one bit in word 7.
    m = '0;
    m[7:0] = '1;
    m[127:120] = '1;
    m[255:248] = '1;
    m[60] = 1'b1;
    run(m, 0, 0, 0, 0, 1);
    // 26 mismatches.
    m[163] = 1'b1;
    run(m, 0, 0, 0, 0, 1);
    // Random valid gaps, all matching.
    run('0, 1, 0, 0, 0, 0);
    // Reset after 100 accepted bits, then a full run on distinct RAM content.
    run('0, 0, 100, 0, 0, 0);
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 11);
    m = '0;
    m[0] = 1'b1;
    m[9] = 1'b1;
    m[100] = 1'b1;
    m[255] = 1'b1;
    run(m, 1, 0, 0, 0, 0);
    // start re-pulsed mid-run and in DONE; next run starts in the following IDLE cycle.
    run(m, 0, 0, 1, 1, 1);
    m[200] = 1'b1;
    run(m, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
